// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status inputs and register enable/flush strobes.
// The datapath side drives the master modport and the controller takes the slave modport.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             mem_pc_mux;
  logic             ld_use;
  logic             wb_halt;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, mem_pc_mux, ld_use, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, halt, stall_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, mem_pc_mux, ld_use, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, halt, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: per-stage enable/flush from hits, hazards and redirects.
// Strobes are combinational from state and inputs; halt state, pending flush and stall counter are registered.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DWAIT = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o;
  logic ifid_flush_o, idex_flush_o, exmem_flush_o, halt_o;
  logic memstall;

  assign memstall = (hz.mem_dREN | hz.mem_dWEN) & ~hz.dhit;

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pc_en_o       = 1'b0;
    ifid_en_o     = 1'b0;
    idex_en_o     = 1'b0;
    exmem_en_o    = 1'b0;
    memwb_en_o    = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    halt_o        = 1'b0;
    if (!RST) begin
      if (state_q == S_HALT) begin
        halt_o = 1'b1;
      end else if (hz.wb_halt) begin
        halt_o  = 1'b1;
        state_d = S_HALT;
      end else if (memstall) begin
        state_d = S_DWAIT;
      end else begin
        state_d = S_RUN;
        if (hz.mem_pc_mux) begin
          idex_en_o     = 1'b1;
          exmem_en_o    = 1'b1;
          memwb_en_o    = 1'b1;
          idex_flush_o  = 1'b1;
          exmem_flush_o = 1'b1;
          // Without a fetch the IF/ID clear cannot land yet, so remember it.
          if (hz.ihit) begin
            pc_en_o      = 1'b1;
            ifid_en_o    = 1'b1;
            ifid_flush_o = 1'b1;
            pend_d       = 1'b0;
          end else begin
            pend_d = 1'b1;
          end
        end else if (hz.ld_use || !hz.ihit) begin
          idex_en_o    = 1'b1;
          idex_flush_o = 1'b1;
          exmem_en_o   = 1'b1;
          memwb_en_o   = 1'b1;
        end else begin
          pc_en_o      = 1'b1;
          ifid_en_o    = 1'b1;
          idex_en_o    = 1'b1;
          exmem_en_o   = 1'b1;
          memwb_en_o   = 1'b1;
          ifid_flush_o = pend_q;
          pend_d       = 1'b0;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!memwb_en_o && state_q != S_HALT && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_RUN;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pc_en       = pc_en_o;
  assign hz.ifid_en     = ifid_en_o;
  assign hz.idex_en     = idex_en_o;
  assign hz.exmem_en    = exmem_en_o;
  assign hz.memwb_en    = memwb_en_o;
  assign hz.ifid_flush  = ifid_flush_o;
  assign hz.idex_flush  = idex_flush_o;
  assign hz.exmem_flush = exmem_flush_o;
  assign hz.halt        = halt_o;
  assign hz.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl built with a 4-bit stall counter.
// Expected strobe vectors are queued as each step is driven and popped when outputs are sampled.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, halt}
  localparam logic [8:0] V_OFF    = 9'b00000_000_0;
  localparam logic [8:0] V_ALL    = 9'b11111_000_0;
  localparam logic [8:0] V_BUB    = 9'b00111_010_0;
  localparam logic [8:0] V_HALT   = 9'b00000_000_1;
  localparam logic [8:0] V_RD_NOI = 9'b00111_011_0;
  localparam logic [8:0] V_RD_I   = 9'b11111_111_0;
  localparam logic [8:0] V_PEND   = 9'b11111_100_0;

  // {ihit, dhit, mem_dREN, mem_dWEN, mem_pc_mux, ld_use, wb_halt}
  localparam logic [6:0] I_RUN    = 7'b1000000;
  localparam logic [6:0] I_LDST   = 7'b1010000;
  localparam logic [6:0] I_LDHIT  = 7'b1110000;
  localparam logic [6:0] I_LDUSE  = 7'b1000010;
  localparam logic [6:0] I_HITNOI = 7'b0110000;
  localparam logic [6:0] I_PC_NOI = 7'b0000100;
  localparam logic [6:0] I_PC_I   = 7'b1000100;
  localparam logic [6:0] I_PRIO   = 7'b1010110;
  localparam logic [6:0] I_PRIOHT = 7'b1110110;
  localparam logic [6:0] I_HALT   = 7'b1001001;

  logic CLK;
  logic RST;
  int   tests;
  int   fails;
  logic [8:0] exp_q[$];

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (hz.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [8:0] obs_vec();
    return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
            hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.halt};
  endfunction

  task automatic apply(input logic [6:0] in_v);
    {hz.ihit, hz.dhit, hz.mem_dREN, hz.mem_dWEN, hz.mem_pc_mux, hz.ld_use, hz.wb_halt} = in_v;
  endtask

  task automatic compare_vec(input string tag);
    logic [8:0] exp_v;
    logic [8:0] got_v;
    #1;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      exp_v = exp_q.pop_front();
      got_v = obs_vec();
      tests++;
      assert (got_v === exp_v) else begin
        fails++;
        $error("FAIL %s observed=%b expected=%b", tag, got_v, exp_v);
      end
    end
  endtask

  // Drive one cycle of inputs away from the rising edge and check the strobes.
  task automatic step(input string tag, input logic [6:0] in_v, input logic [8:0] exp_v);
    @(negedge CLK);
    apply(in_v);
    exp_q.push_back(exp_v);
    compare_vec(tag);
  endtask

  // Let the edge for the preceding step happen, then check the counter.
  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp_c);
    @(posedge CLK);
    #1;
    tests++;
    assert (hz.stall_cnt === exp_c) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, hz.stall_cnt, exp_c);
    end
  endtask

  task automatic rst_check(input string tag);
    @(negedge CLK);
    RST = 1'b1;
    apply(I_RUN);
    exp_q.push_back(V_OFF);
    compare_vec(tag);
    tests++;
    assert (hz.stall_cnt === '0) else begin
      fails++;
      $error("FAIL %s_cnt observed=%0d expected=0", tag, hz.stall_cnt);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RST   = 1'b1;
    apply(I_RUN);
    exp_q.push_back(V_OFF);
    #2;
    compare_vec("reset_vec");
    tests++;
    assert (hz.stall_cnt === '0) else begin
      fails++;
      $error("FAIL reset_cnt observed=%0d expected=0", hz.stall_cnt);
    end
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 3; i++) step("run", I_RUN, V_ALL);
    chk_cnt("run_cnt", 4'd0);

    for (int i = 0; i < 3; i++) step("dwait", I_LDST, V_OFF);
    step("dwait_hit", I_LDHIT, V_ALL);
    chk_cnt("dwait_cnt", 4'd3);

    step("lduse", I_LDUSE, V_BUB);
    chk_cnt("lduse_cnt", 4'd3);

    step("ld_again", I_LDST, V_OFF);
    step("dhit_noihit", I_HITNOI, V_BUB);
    chk_cnt("dhit_noihit_cnt", 4'd4);

    step("redir_noihit", I_PC_NOI, V_RD_NOI);
    step("redir_pending", I_RUN, V_PEND);
    step("redir_cleared", I_RUN, V_ALL);
    step("redir_ihit", I_PC_I, V_RD_I);
    step("redir_after", I_RUN, V_ALL);

    step("prio_memstall", I_PRIO, V_OFF);
    step("prio_redir", I_PRIOHT, V_RD_I);
    chk_cnt("prio_cnt", 4'd5);

    for (int i = 0; i < 10; i++) step("sat", I_LDST, V_OFF);
    chk_cnt("sat_reach", 4'd15);
    for (int i = 0; i < 11; i++) step("sat", I_LDST, V_OFF);
    chk_cnt("sat_hold", 4'd15);

    step("halt_enter", I_HALT, V_HALT);
    step("halt_run", I_RUN, V_HALT);
    step("halt_redir", I_PC_I, V_HALT);
    step("halt_ld", I_LDHIT, V_HALT);

    rst_check("halt_rst");
    step("post_rst", I_RUN, V_ALL);
    chk_cnt("post_rst_cnt", 4'd0);
    step("one_stall", I_LDST, V_OFF);
    chk_cnt("one_stall_cnt", 4'd1);
    step("halt2", I_HALT, V_HALT);
    chk_cnt("halt2_cnt", 4'd2);
    step("halt2_hold", I_LDST, V_HALT);
    step("halt2_hold", I_RUN, V_HALT);
    chk_cnt("halt2_frozen", 4'd2);

    rst_check("halt2_rst");
    step("dwait_mid", I_LDST, V_OFF);
    step("dwait_mid", I_LDST, V_OFF);
    rst_check("dwait_rst");
    step("after_dwait_rst", I_RUN, V_ALL);
    chk_cnt("after_dwait_rst_cnt", 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
